// File: rtl/time_set_encoder_pkg.sv
// Shared definitions for time_set_encoder: field layout, range limits, FSM
// encoding and calendar helpers. ALARM_EDIT_EN adds the EDIT_ALARM state.
package time_set_encoder_pkg;

    localparam int TIME_W  = 17;
    localparam int DATE_W  = 16;
    localparam int FIELD_W = 7;

    localparam int HOUR_LSB  = 12;
    localparam int HOUR_W    = 5;
    localparam int MIN_LSB   = 6;
    localparam int MIN_W     = 6;
    localparam int SEC_LSB   = 0;
    localparam int SEC_W     = 6;
    localparam int YEAR_LSB  = 9;
    localparam int YEAR_W    = 7;
    localparam int MONTH_LSB = 5;
    localparam int MONTH_W   = 4;
    localparam int DAY_LSB   = 0;
    localparam int DAY_W     = 5;

    localparam logic [FIELD_W-1:0] HOUR_MAX   = 7'd23;
    localparam logic [FIELD_W-1:0] MINSEC_MAX = 7'd59;
    localparam logic [FIELD_W-1:0] MONTH_MIN  = 7'd1;
    localparam logic [FIELD_W-1:0] MONTH_MAX  = 7'd12;
    localparam logic [FIELD_W-1:0] DAY_MIN    = 7'd1;

    typedef enum logic [1:0] {
        IDLE,
        EDIT_TIME,
        EDIT_DATE
`ifdef ALARM_EDIT_EN
        , EDIT_ALARM
`endif
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_CANCEL,
        ACT_MODE,
        ACT_NEXT,
        ACT_UP,
        ACT_DOWN
    } action_t;

    // f0 = hour/year, f1 = min/month, f2 = sec/day
    typedef struct packed {
        logic [FIELD_W-1:0] f0;
        logic [FIELD_W-1:0] f1;
        logic [FIELD_W-1:0] f2;
    } fields_t;

    function automatic logic [FIELD_W-1:0] days_in_month(input logic [FIELD_W-1:0] month,
                                                         input logic [FIELD_W-1:0] year);
        case (month)
            7'd2:                      return ((year % 7'd4) == 7'd0) ? 7'd29 : 7'd28;
            7'd4, 7'd6, 7'd9, 7'd11:   return 7'd30;
            default:                   return 7'd31;
        endcase
    endfunction

    function automatic fields_t snap_time(input logic [TIME_W-1:0] t);
        fields_t f;
        f.f0 = FIELD_W'(t[HOUR_LSB +: HOUR_W]);
        f.f1 = FIELD_W'(t[MIN_LSB +: MIN_W]);
        f.f2 = FIELD_W'(t[SEC_LSB +: SEC_W]);
        if (f.f0 > HOUR_MAX)   f.f0 = '0;
        if (f.f1 > MINSEC_MAX) f.f1 = '0;
        if (f.f2 > MINSEC_MAX) f.f2 = '0;
        return f;
    endfunction

    function automatic fields_t snap_date(input logic [DATE_W-1:0] d,
                                          input logic [FIELD_W-1:0] year_max);
        fields_t f;
        f.f0 = FIELD_W'(d[YEAR_LSB +: YEAR_W]);
        f.f1 = FIELD_W'(d[MONTH_LSB +: MONTH_W]);
        f.f2 = FIELD_W'(d[DAY_LSB +: DAY_W]);
        if (f.f0 > year_max) f.f0 = '0;
        if (f.f1 < MONTH_MIN || f.f1 > MONTH_MAX) f.f1 = MONTH_MIN;
        if (f.f2 < DAY_MIN || f.f2 > days_in_month(f.f1, f.f0)) f.f2 = DAY_MIN;
        return f;
    endfunction

    function automatic logic [TIME_W-1:0] pack_time(input fields_t f);
        return {f.f0[HOUR_W-1:0], f.f1[MIN_W-1:0], f.f2[SEC_W-1:0]};
    endfunction

    function automatic logic [DATE_W-1:0] pack_date(input fields_t f);
        return {f.f0[YEAR_W-1:0], f.f1[MONTH_W-1:0], f.f2[DAY_W-1:0]};
    endfunction

endpackage

// File: rtl/time_set_encoder_wrap_step.sv
// wt_wrap_step: one-step increment/decrement of a value inside [i_min, i_max]
// with wrap-around; simultaneous up and down leave the value unchanged.
module wt_wrap_step #(
    parameter int W = 7
) (
    input  logic [W-1:0] i_value,
    input  logic [W-1:0] i_min,
    input  logic [W-1:0] i_max,
    input  logic         i_up,
    input  logic         i_down,
    output logic [W-1:0] o_next
);

    // NOTE: default assigned first so every path drives o_next and no latch is inferred.
    always_comb begin
        o_next = i_value;
        if (i_up && !i_down) begin
            o_next = (i_value >= i_max) ? i_min : i_value + W'(1);
        end else if (i_down && !i_up) begin
            o_next = (i_value <= i_min) ? i_max : i_value - W'(1);
        end
    end

endmodule

// File: rtl/time_set_encoder.sv
// Button-driven editor for time/date (and alarm time when ALARM_EDIT_EN is
// defined) with wrap-around fields and one-cycle commit strobes.
module time_set_encoder
    import time_set_encoder_pkg::*;
#(
    parameter int RESET_YEAR = 16,
    parameter int YEAR_MAX   = 99
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [TIME_W-1:0] IN_TIME,
    input  logic [DATE_W-1:0] IN_DATE,
    input  logic              BTN_MODE,
    input  logic              BTN_NEXT,
    input  logic              BTN_UP,
    input  logic              BTN_DOWN,
    input  logic              BTN_CANCEL,
    output logic [TIME_W-1:0] OUT_TIME,
    output logic [DATE_W-1:0] OUT_DATE,
    output logic              OUT_TIME_LOAD,
    output logic              OUT_DATE_LOAD,
    output logic              OUT_EDIT,
`ifdef ALARM_EDIT_EN
    input  logic [TIME_W-1:0] IN_ALARM_TIME,
    output logic [TIME_W-1:0] OUT_ALARM_TIME,
    output logic              OUT_ALARM_LOAD,
`endif
    output logic [1:0]        OUT_FIELD
);

    localparam logic [FIELD_W-1:0] YEAR_MAX_L   = FIELD_W'(YEAR_MAX);
    localparam logic [FIELD_W-1:0] RESET_YEAR_L = FIELD_W'(RESET_YEAR);

    state_t              r_state, w_state_next;
    action_t             w_action;
    fields_t             r_edit;
    logic [1:0]          r_field;
    logic [TIME_W-1:0]   r_out_time;
    logic [DATE_W-1:0]   r_out_date;
    logic                r_time_load, r_date_load;
`ifdef ALARM_EDIT_EN
    logic [TIME_W-1:0]   r_out_alarm;
    logic                r_alarm_load;
`endif

    logic [FIELD_W-1:0]  w_val  [3];
    logic [FIELD_W-1:0]  w_min  [3];
    logic [FIELD_W-1:0]  w_max  [3];
    logic [FIELD_W-1:0]  w_step [3];
    logic [2:0]          w_up, w_down;
    logic                w_date_mode;
    logic [FIELD_W-1:0]  w_day_lim_new, w_day_new;
    fields_t             w_edit_committed;

    // Priority CANCEL > MODE > NEXT > UP/DOWN; IDLE only reacts to MODE.
    always_comb begin
        w_action = ACT_NONE;
        if (BTN_CANCEL)                w_action = ACT_CANCEL;
        else if (BTN_MODE)             w_action = ACT_MODE;
        else if (BTN_NEXT)             w_action = ACT_NEXT;
        else if (BTN_UP && !BTN_DOWN)  w_action = ACT_UP;
        else if (BTN_DOWN && !BTN_UP)  w_action = ACT_DOWN;
        if (r_state == IDLE && w_action != ACT_MODE) w_action = ACT_NONE;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_action == ACT_CANCEL) begin
            w_state_next = IDLE;
        end else if (w_action == ACT_MODE) begin
            case (r_state)
                IDLE:      w_state_next = EDIT_TIME;
                EDIT_TIME: w_state_next = EDIT_DATE;
`ifdef ALARM_EDIT_EN
                EDIT_DATE: w_state_next = EDIT_ALARM;
`else
                EDIT_DATE: w_state_next = IDLE;
`endif
                default:   w_state_next = IDLE;
            endcase
        end
    end

    // NOTE: asynchronous reset on every register, including the edit copy, so no stale edit survives reset.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    assign w_date_mode = (r_state == EDIT_DATE);
    assign w_val[0]    = r_edit.f0;
    assign w_val[1]    = r_edit.f1;
    assign w_val[2]    = r_edit.f2;

    always_comb begin
        w_min[0] = '0;
        w_max[0] = HOUR_MAX;
        w_min[1] = '0;
        w_max[1] = MINSEC_MAX;
        w_min[2] = '0;
        w_max[2] = MINSEC_MAX;
        if (w_date_mode) begin
            w_max[0] = YEAR_MAX_L;
            w_min[1] = MONTH_MIN;
            w_max[1] = MONTH_MAX;
            w_min[2] = DAY_MIN;
            w_max[2] = days_in_month(r_edit.f1, r_edit.f0);
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_step
        assign w_up[k]   = (w_action == ACT_UP)   && (r_field == 2'(k));
        assign w_down[k] = (w_action == ACT_DOWN) && (r_field == 2'(k));
        wt_wrap_step #(.W(FIELD_W)) u_step (
            .i_value (w_val[k]),
            .i_min   (w_min[k]),
            .i_max   (w_max[k]),
            .i_up    (w_up[k]),
            .i_down  (w_down[k]),
            .o_next  (w_step[k])
        );
    end

    // A month or year change may leave the day past the end of the new month.
    assign w_day_lim_new = days_in_month(w_step[1], w_step[0]);
    assign w_day_new     = (w_date_mode && w_step[2] > w_day_lim_new) ? w_day_lim_new : w_step[2];
    assign w_edit_committed = r_edit;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_edit      <= '{f0: RESET_YEAR_L, f1: 7'd1, f2: 7'd1};
            r_field     <= '0;
            r_out_time  <= '0;
            r_out_date  <= {RESET_YEAR_L, 4'd1, 5'd1};
            r_time_load <= 1'b0;
            r_date_load <= 1'b0;
`ifdef ALARM_EDIT_EN
            r_out_alarm  <= '0;
            r_alarm_load <= 1'b0;
`endif
        end else begin
            r_time_load <= 1'b0;
            r_date_load <= 1'b0;
`ifdef ALARM_EDIT_EN
            r_alarm_load <= 1'b0;
`endif
            case (w_action)
                ACT_CANCEL: r_field <= '0;
                ACT_MODE: begin
                    r_field <= '0;
                    case (r_state)
                        IDLE: r_edit <= snap_time(IN_TIME);
                        EDIT_TIME: begin
                            r_out_time  <= pack_time(w_edit_committed);
                            r_time_load <= 1'b1;
                            r_edit      <= snap_date(IN_DATE, YEAR_MAX_L);
                        end
                        EDIT_DATE: begin
                            r_out_date  <= pack_date(w_edit_committed);
                            r_date_load <= 1'b1;
`ifdef ALARM_EDIT_EN
                            r_edit      <= snap_time(IN_ALARM_TIME);
`endif
                        end
`ifdef ALARM_EDIT_EN
                        EDIT_ALARM: begin
                            r_out_alarm  <= pack_time(w_edit_committed);
                            r_alarm_load <= 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                ACT_NEXT: r_field <= (r_field == 2'd2) ? 2'd0 : r_field + 2'd1;
                ACT_UP, ACT_DOWN: begin
                    r_edit.f0 <= w_step[0];
                    r_edit.f1 <= w_step[1];
                    r_edit.f2 <= w_day_new;
                end
                default: ;
            endcase
        end
    end

    assign OUT_TIME      = r_out_time;
    assign OUT_DATE      = r_out_date;
    assign OUT_TIME_LOAD = r_time_load;
    assign OUT_DATE_LOAD = r_date_load;
    assign OUT_EDIT      = (r_state != IDLE);
    assign OUT_FIELD     = r_field;
`ifdef ALARM_EDIT_EN
    assign OUT_ALARM_TIME = r_out_alarm;
    assign OUT_ALARM_LOAD = r_alarm_load;
`endif

endmodule
